// File: rtl/demux_dispatch_ctrl.sv
// One-word 1x4 dispatcher: holds an accepted word and offers it to a round-robin
// target channel, stepping to the next channel on timeout. Optional DISPATCH_STATS_EN adds counters.
module demux_dispatch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
`ifdef DISPATCH_STATS_EN
  output logic [15:0]       grant_cnt,
  output logic [15:0]       retarget_cnt,
`endif
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Wait counter value on which an unaccepted offer moves to the next channel.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        w_ptr_nxt;
  logic [1:0]        r_sel;
  logic [1:0]        w_sel_nxt;
  logic [7:0]        r_wait;
  logic [7:0]        w_wait_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_sel_ready;
  logic              w_wait_last;

  assign w_sel_ready = out_ready[r_sel];
  assign w_wait_last = (r_wait == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 2'b00;
      r_sel   <= 2'b00;
      r_wait  <= 8'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_wait  <= w_wait_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_wait_nxt  = r_wait;
    w_data_nxt  = r_data;
    in_ready    = 1'b0;
    out_valid   = 4'b0000;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_data_nxt  = in_data;
          w_sel_nxt   = r_ptr;
          w_wait_nxt  = 8'd0;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        busy      = 1'b1;
        out_valid = 4'b0001 << r_sel;
        // Acceptance takes priority over a coincident timeout step.
        if (w_sel_ready) begin
          w_ptr_nxt   = r_sel + 2'd1;
          w_state_nxt = IDLE;
        end else if (w_wait_last) begin
          w_sel_nxt  = r_sel + 2'd1;
          w_wait_nxt = 8'd0;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign out_data = r_data;
  assign sel      = r_sel;

`ifdef DISPATCH_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    sat_inc16 = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  logic        w_grant;
  logic        w_retarget;
  logic [15:0] r_grant_cnt;
  logic [15:0] r_retarget_cnt;

  assign w_grant    = (r_state == OFFER) && w_sel_ready;
  assign w_retarget = (r_state == OFFER) && !w_sel_ready && w_wait_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt    <= 16'd0;
      r_retarget_cnt <= 16'd0;
    end else begin
      if (w_grant)    r_grant_cnt    <= sat_inc16(r_grant_cnt);
      if (w_retarget) r_retarget_cnt <= sat_inc16(r_retarget_cnt);
    end
  end

  assign grant_cnt    = r_grant_cnt;
  assign retarget_cnt = r_retarget_cnt;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: table-driven vectors, timeout/reset sequences,
// and a delivery scoreboard fed as words are sent.
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] sel;
  logic       busy;
`ifdef DISPATCH_STATS_EN
  logic [15:0] grant_cnt;
  logic [15:0] retarget_cnt;
`endif

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel),
`ifdef DISPATCH_STATS_EN
    .grant_cnt(grant_cnt), .retarget_cnt(retarget_cnt),
`endif
    .busy(busy)
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [3:0] rdy;
    logic       push;
    logic [1:0] pch;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [1:0] e_sel;
    logic       e_busy;
    logic [7:0] e_data;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string nm, input logic ir, input logic [3:0] ov,
                           input logic [1:0] s, input logic b, input logic [7:0] d);
    chk({nm, ".in_ready"},  32'(in_ready),  32'(ir));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".sel"},       32'(sel),       32'(s));
    chk({nm, ".busy"},      32'(busy),      32'(b));
    chk({nm, ".out_data"},  32'(out_data),  32'(d));
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic [3:0] rdy,
                              input logic push, input logic [1:0] pch, input logic e_ir,
                              input logic [3:0] e_ov, input logic [1:0] e_sel,
                              input logic e_busy, input logic [7:0] e_data);
    vec_t v;
    v.iv = iv; v.d = d; v.rdy = rdy; v.push = push; v.pch = pch;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_sel = e_sel; v.e_busy = e_busy; v.e_data = e_data;
    return v;
  endfunction

  // Delivery monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (out_valid & out_ready) != 4'b0000) begin
      if (sbq.size() == 0) begin
        chk("sb.unexpected_delivery", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb.data",    32'(out_data),  32'(mon_e.d));
        chk("sb.channel", 32'(out_valid), 32'(4'b0001 << mon_e.ch));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic push, input logic [1:0] ch);
    in_valid = 1'b1;
    in_data  = d;
    if (push) sbq.push_back({d, ch});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with in_valid asserted and ignored.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk_state("post_reset", 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00);

    // Round-robin delivery, 1 word per 2 cycles; in_data ignored while offering.
    vecs.push_back(mk(1, 8'hA1, 4'hF, 1, 2'd0, 0, 4'b0001, 2'd0, 1, 8'hA1));
    vecs.push_back(mk(1, 8'hEE, 4'hF, 0, 2'd0, 1, 4'b0000, 2'd0, 0, 8'hA1));
    vecs.push_back(mk(1, 8'hA2, 4'hF, 1, 2'd1, 0, 4'b0010, 2'd1, 1, 8'hA2));
    vecs.push_back(mk(1, 8'hEE, 4'hF, 0, 2'd0, 1, 4'b0000, 2'd1, 0, 8'hA2));
    vecs.push_back(mk(1, 8'hA3, 4'hF, 1, 2'd2, 0, 4'b0100, 2'd2, 1, 8'hA3));
    vecs.push_back(mk(1, 8'hEE, 4'hF, 0, 2'd0, 1, 4'b0000, 2'd2, 0, 8'hA3));
    vecs.push_back(mk(1, 8'hA4, 4'hF, 1, 2'd3, 0, 4'b1000, 2'd3, 1, 8'hA4));
    vecs.push_back(mk(1, 8'hEE, 4'hF, 0, 2'd0, 1, 4'b0000, 2'd3, 0, 8'hA4));
    vecs.push_back(mk(1, 8'hA5, 4'hF, 1, 2'd0, 0, 4'b0001, 2'd0, 1, 8'hA5));
    vecs.push_back(mk(1, 8'hEE, 4'hF, 0, 2'd0, 1, 4'b0000, 2'd0, 0, 8'hA5));
    // Non-selected ready bits are ignored.
    vecs.push_back(mk(1, 8'hB6, 4'hF, 1, 2'd1, 0, 4'b0010, 2'd1, 1, 8'hB6));
    vecs.push_back(mk(0, 8'h00, 4'b1101, 0, 2'd0, 0, 4'b0010, 2'd1, 1, 8'hB6));
    vecs.push_back(mk(0, 8'h00, 4'b0010, 0, 2'd0, 1, 4'b0000, 2'd1, 0, 8'hB6));

    foreach (vecs[i]) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].rdy;
      if (vecs[i].push) sbq.push_back({vecs[i].d, vecs[i].pch});
      @(posedge clk); #1;
      chk_state($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_sel,
                vecs[i].e_busy, vecs[i].e_data);
    end
    in_valid = 1'b0;

    // Timeout walk across channels, delivery on ch2, next word targets ch3.
    do_reset();
    send(8'h55, 1'b1, 2'd2);
    for (int k = 0; k < 15; k++) begin
      chk("to.ch0.out_valid", 32'(out_valid), 32'(4'b0001));
      chk("to.ch0.in_ready",  32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 15; k++) begin
      chk("to.ch1.out_valid", 32'(out_valid), 32'(4'b0010));
      chk("to.ch1.out_data",  32'(out_data),  32'h55);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk("to.ch2.out_valid", 32'(out_valid), 32'(4'b0100));
      @(posedge clk); #1;
    end
    out_ready = 4'b0100;
    @(posedge clk); #1;
    chk_state("to.delivered", 1'b1, 4'b0000, 2'd2, 1'b0, 8'h55);
    out_ready = 4'b0000;
    send(8'h66, 1'b1, 2'd0);
    for (int k = 0; k < 15; k++) begin
      chk("to.ch3.out_valid", 32'(out_valid), 32'(4'b1000));
      @(posedge clk); #1;
    end
    chk_state("to.wrap", 1'b0, 4'b0001, 2'd0, 1'b1, 8'h66);
    out_ready = 4'b0001;
    @(posedge clk); #1;
    chk("to.wrap.busy", 32'(busy), 32'd0);

    // Ready on a non-selected channel does not transfer.
    do_reset();
    out_ready = 4'b0010;
    send(8'h77, 1'b1, 2'd1);
    for (int k = 0; k < 15; k++) begin
      chk("ns.hold.out_valid", 32'(out_valid), 32'(4'b0001));
      @(posedge clk); #1;
    end
    chk("ns.step.out_valid", 32'(out_valid), 32'(4'b0010));
    @(posedge clk); #1;
    chk_state("ns.delivered", 1'b1, 4'b0000, 2'd1, 1'b0, 8'h77);

    // Acceptance on the exact timeout cycle wins.
    out_ready = 4'b0000;
    send(8'h88, 1'b1, 2'd2);
    repeat (14) @(posedge clk);
    #1;
    chk("tie.pre.sel", 32'(sel), 32'd2);
    out_ready = 4'b0100;
    @(posedge clk); #1;
    chk_state("tie.after", 1'b1, 4'b0000, 2'd2, 1'b0, 8'h88);
    out_ready = 4'b1111;
    send(8'h99, 1'b1, 2'd3);
    chk("tie.next.sel", 32'(sel), 32'd3);
    @(posedge clk); #1;

    // Asynchronous reset while offering on ch2 discards the word.
    do_reset();
    out_ready = 4'b1111;
    send(8'hC0, 1'b1, 2'd0);
    @(posedge clk); #1;
    send(8'hC1, 1'b1, 2'd1);
    @(posedge clk); #1;
    out_ready = 4'b0000;
    send(8'hC2, 1'b0, 2'd0);
    chk_state("ar.offer", 1'b0, 4'b0100, 2'd2, 1'b1, 8'hC2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("ar.async", 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00);
    in_valid = 1'b1; in_data = 8'hDD;
    @(posedge clk); #1;
    chk_state("ar.held", 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00);
    in_valid = 1'b0; rst_n = 1'b1; out_ready = 4'b1111;
    send(8'hC3, 1'b1, 2'd0);
    chk_state("ar.next", 1'b0, 4'b0001, 2'd0, 1'b1, 8'hC3);
    @(posedge clk); #1;

`ifdef DISPATCH_STATS_EN
    do_reset();
    chk("st.grant0", 32'(grant_cnt), 32'd0);
    chk("st.retarget0", 32'(retarget_cnt), 32'd0);
    out_ready = 4'b1111;
    send(8'h01, 1'b1, 2'd0);
    @(posedge clk); #1;
    send(8'h02, 1'b1, 2'd1);
    @(posedge clk); #1;
    out_ready = 4'b0000;
    send(8'h03, 1'b1, 2'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("st.sel_after_steps", 32'(sel), 32'd0);
    out_ready = 4'b0001;
    @(posedge clk); #1;
    chk("st.grant3", 32'(grant_cnt), 32'd3);
    chk("st.retarget2", 32'(retarget_cnt), 32'd2);
    force dut.r_grant_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.r_grant_cnt;
    out_ready = 4'b1111;
    send(8'h04, 1'b1, 2'd1);
    @(posedge clk); #1;
    send(8'h05, 1'b1, 2'd2);
    @(posedge clk); #1;
    chk("st.grant_sat", 32'(grant_cnt), 32'hFFFF);
`endif

    chk("sb.empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter TIMEOUT, default 15, cycles a word waits on one channel before re-targeting the next; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  DATA_W  upstream payload.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 out_data  output  DATA_W  held payload, common to all four channels.
REQ-009 out_valid  output  4  one-hot offer; bit n targets channel n.
REQ-010 out_ready  input  4  per-channel acceptance.
REQ-011 sel  output  2  current target channel, binary; drives the 1x4 demux select (sel[1]=sel1, sel[0]=sel0).
REQ-012 busy  output  1  high while a word is held.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and OFFER.
REQ-014 The block SHALL drive in_ready=1 in IDLE and 0 in OFFER.
REQ-015 In IDLE with in_valid=1, the block SHALL latch in_data into out_data, load sel from the round-robin pointer ptr, clear wait counter, and enter OFFER on that edge.
REQ-016 In OFFER, out_valid SHALL be one-hot at bit sel; in IDLE, out_valid SHALL be 4'b0000.
REQ-017 In OFFER with out_ready[sel]=1, transfer completes that edge: ptr <= sel+1 (mod 4), state <= IDLE.
REQ-018 In OFFER with out_ready[sel]=0, wait SHALL increment; when wait reaches TIMEOUT-1 without acceptance, sel <= sel+1 (mod 4), wait <= 0, state stays OFFER, out_data unchanged.
REQ-019 Acceptance and timeout on the same edge: acceptance wins, sel does not advance.
REQ-020 out_ready bits other than out_ready[sel] SHALL be ignored.
REQ-021 out_data and sel SHALL be stable for the whole OFFER period except the REQ-018 sel step; no word is ever dropped or duplicated.
REQ-022 Throughput SHALL be at most one word per 2 cycles (accept in IDLE, deliver earliest next cycle).
REQ-023 busy SHALL equal (state==OFFER).
REQ-024 wait counter SHALL be 8 bits and wrap only via REQ-018.

Reset
REQ-025 While rst_n=0: state=IDLE, ptr=0, sel=2'b00, wait=0, out_data=0, out_valid=0, busy=0, in_ready=1; in_valid ignored.
REQ-026 Reset asserted mid-OFFER SHALL discard the held word immediately (asynchronously); first post-reset word targets channel 0.

Configuration
REQ-027 Macro DISPATCH_STATS_EN: when defined, add output grant_cnt (16 bits) counting completed transfers (REQ-017), saturating at 16'hFFFF, reset 0, and output retarget_cnt (16 bits) counting REQ-018 steps, saturating, reset 0.
REQ-028 When DISPATCH_STATS_EN is undefined, these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset, all out_ready=1, send 8'hA1,A2,A3,A4,A5 -> delivered on channels 0,1,2,3,0 in order, one per 2 cycles, sel matches each.
REQ-030 out_ready=4'b0000, send 8'h55, TIMEOUT=15 -> out_valid 0001 for 15 cycles, then 0010, 0100, 1000, 0001; in_ready=0 throughout; raise out_ready[2] during the 0100 period -> delivered on ch2, next word targets ch3.
REQ-031 Only out_ready[1]=1 while sel=0 -> no transfer on ch1; word stays on ch0 until timeout.
REQ-032 out_ready[sel] rises on exact timeout cycle -> delivered on current sel, sel not advanced.
REQ-033 Assert rst_n=0 mid-OFFER on ch2 -> out_valid=0, busy=0, sel=0 immediately; next word goes to ch0.
REQ-034 With DISPATCH_STATS_EN: 3 transfers plus 2 retargets -> grant_cnt=3, retarget_cnt=2; force 65536 transfers -> grant_cnt=16'hFFFF.
